// File: rtl/dibit_tx.sv
// -----------------------------------------------------------------------------
// dibit_tx
//
// Byte-to-dibit line transmitter. Each accepted byte goes out on a 2-bit
// symbol bus as one preamble symbol (2'b11) and then four data dibits, most
// significant dibit first. Every symbol is held for SYM_PERIOD clocks. While
// no frame is in progress the bus carries IDLE_SYM. The registered `out` bus
// connects straight to the 2-bit input register of the receiving side.
//
// Parameters
//   SYM_PERIOD  clocks per symbol, >= 1 (1 gives one clock per symbol)
//   IDLE_SYM    symbol driven between frames; must differ from 2'b11 so the
//               receiver can find the preamble
//
// Ports
//   sys_clk     in   clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset; abandons any frame
//   tx_data     in   [7:0] byte to send, sampled only on accept
//   tx_valid    in   tx_data is valid
//   tx_ready    out  block can accept a byte (registered, high only in IDLE)
//   out         out  [1:0] symbol bus (registered)
//   busy        out  a frame is in progress (registered)
//   frame_done  out  one-cycle pulse on the first IDLE cycle after a frame
//
// Frame timing, with E the accepting edge and P = SYM_PERIOD:
//   after E .. E+P-1          out = 2'b11 (preamble)
//   after E+(k+1)P, P clocks  out = dibit k, k = 0..3
//   after E+5P                out = IDLE_SYM, tx_ready = 1, frame_done = 1
//   earliest next accept      edge E+5P+1
// -----------------------------------------------------------------------------
module dibit_tx #(
    parameter int unsigned SYM_PERIOD = 4,
    parameter logic [1:0]  IDLE_SYM   = 2'b00
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [1:0] out,
    output logic       busy,
    output logic       frame_done
);

    // Symbol counter runs 0..SYM_PERIOD-1. With SYM_PERIOD = 1 it never
    // leaves 0 and every cycle is a terminal count, so each symbol lasts
    // exactly one clock. $clog2(1) is 0, hence the floor of one bit.
    localparam int unsigned     CNT_W    = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_PERIOD - 1);
    localparam logic [1:0]      PRE_SYM  = 2'b11;
    localparam logic [1:0]      LAST_IDX = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] sym_cnt;
    logic [1:0]       dibit_idx;
    logic [7:0]       shift_reg;

    logic accept;
    logic sym_last;

    // tx_ready is the registered image of (state == ST_IDLE), so an accept
    // can only ever start from IDLE and tx_valid is ignored mid-frame.
    assign accept   = tx_valid && tx_ready;
    assign sym_last = (sym_cnt == CNT_LAST);

    // The byte is latched once on accept and shifted left two bits per data
    // symbol; the next dibit to send always sits in shift_reg[7:6]. This keeps
    // the frame immune to tx_data changing after the handshake.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: every state bit, including the byte shift register, has an
            // async reset value; a frame cut short by reset leaves nothing
            // behind and never produces a frame_done pulse.
            state      <= ST_IDLE;
            sym_cnt    <= '0;
            dibit_idx  <= '0;
            shift_reg  <= '0;
            out        <= IDLE_SYM;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: all state updates here are non-blocking so every register
            // sees the pre-edge values of the others, independent of the order
            // of statements below.
            frame_done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_PRE;
                        shift_reg <= tx_data;
                        sym_cnt   <= '0;
                        dibit_idx <= '0;
                        out       <= PRE_SYM;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                ST_PRE: begin
                    if (sym_last) begin
                        // Preamble finished: present dibit 0 (tx_data[7:6]).
                        state     <= ST_DATA;
                        sym_cnt   <= '0;
                        dibit_idx <= '0;
                        out       <= shift_reg[7:6];
                        shift_reg <= {shift_reg[5:0], 2'b00};
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (sym_last) begin
                        sym_cnt <= '0;
                        if (dibit_idx == LAST_IDX) begin
                            // Last dibit done: back to IDLE; the done pulse
                            // coincides with the first IDLE cycle.
                            state      <= ST_IDLE;
                            out        <= IDLE_SYM;
                            tx_ready   <= 1'b1;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            dibit_idx <= dibit_idx + 2'd1;
                            out       <= shift_reg[7:6];
                            shift_reg <= {shift_reg[5:0], 2'b00};
                        end
                    end else begin
                        sym_cnt <= sym_cnt + 1'b1;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a clean IDLE.
                    state     <= ST_IDLE;
                    sym_cnt   <= '0;
                    dibit_idx <= '0;
                    out       <= IDLE_SYM;
                    tx_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dibit_tx.sv
// -----------------------------------------------------------------------------
// tb_dibit_tx
//
// Self-checking bench for dibit_tx. Two instances share all inputs: one with
// SYM_PERIOD = 4 and one with SYM_PERIOD = 1; `sel_p1` picks which one is
// observed. Before each frame the bench pushes the cycle-by-cycle expected
// outputs (symbol, tx_ready, busy, frame_done) into a queue from its own model
// of the frame timing; each sample after the accepting edge pops one entry
// and compares it. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dibit_tx;

    localparam logic [1:0] IDLE_SYM = 2'b00;

    typedef struct packed {
        logic [1:0] sym;
        logic       ready;
        logic       busy;
        logic       done;
    } obs_t;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;

    logic       tx_ready4, busy4, frame_done4;
    logic [1:0] out4;
    logic       tx_ready1, busy1, frame_done1;
    logic [1:0] out1;

    logic sel_p1;
    obs_t obs;

    obs_t q[$];
    int   checks;
    int   errors;

    dibit_tx #(.SYM_PERIOD(4), .IDLE_SYM(IDLE_SYM)) dut4 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready4),
        .out        (out4),
        .busy       (busy4),
        .frame_done (frame_done4)
    );

    dibit_tx #(.SYM_PERIOD(1), .IDLE_SYM(IDLE_SYM)) dut1 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready1),
        .out        (out1),
        .busy       (busy1),
        .frame_done (frame_done1)
    );

    assign obs = sel_p1 ? {out1, tx_ready1, busy1, frame_done1}
                        : {out4, tx_ready4, busy4, frame_done4};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // One frame: P preamble cycles, then 4 dibits MSB first, P cycles each.
    task automatic push_frame(input logic [7:0] d, input int p);
        obs_t       e;
        logic [1:0] dib;
        for (int i = 0; i < p; i++) begin
            e = '{sym: 2'b11, ready: 1'b0, busy: 1'b1, done: 1'b0};
            q.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            dib = d[7 - 2*k -: 2];
            for (int i = 0; i < p; i++) begin
                e = '{sym: dib, ready: 1'b0, busy: 1'b1, done: 1'b0};
                q.push_back(e);
            end
        end
    endtask

    task automatic push_idle(input logic done);
        obs_t e;
        e = '{sym: IDLE_SYM, ready: 1'b1, busy: 1'b0, done: done};
        q.push_back(e);
    endtask

    task automatic settle(input int n);
        tx_valid = 1'b0;
        repeat (n) @(negedge sys_clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        obs_t exp_o;
        exp_o = '{sym: IDLE_SYM, ready: 1'b1, busy: 1'b0, done: 1'b0};
        sys_rst_n = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        repeat (3) @(negedge sys_clk);
        for (int s = 0; s < 2; s++) begin
            sel_p1 = s[0];
            #1;
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL reset_hold p1=%0d: got %b exp %b", s, obs, exp_o);
            end
        end
        sel_p1 = 1'b0;
        sys_rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge sys_clk);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %b exp %b", j, obs, exp_o);
            end
        end
    endtask

    task automatic test_single_frame();
        obs_t e;
        sel_p1 = 1'b0;
        q.delete();
        push_frame(8'hB4, 4);
        push_idle(1'b1);
        push_idle(1'b0);
        @(negedge sys_clk);
        tx_data  = 8'hB4;
        tx_valid = 1'b1;
        @(posedge sys_clk);
        for (int j = 0; q.size() > 0; j++) begin
            @(negedge sys_clk);
            if (j == 0) tx_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL single_frame[%0d]: got sym=%b rdy=%b busy=%b done=%b exp sym=%b rdy=%b busy=%b done=%b",
                         j, obs.sym, obs.ready, obs.busy, obs.done, e.sym, e.ready, e.busy, e.done);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        sel_p1 = 1'b0;
        q.delete();
        push_frame(8'h1B, 4);
        push_idle(1'b1);
        push_frame(8'hE4, 4);
        push_idle(1'b1);
        push_idle(1'b0);
        @(negedge sys_clk);
        tx_data  = 8'h1B;
        tx_valid = 1'b1;
        @(posedge sys_clk);
        for (int j = 0; q.size() > 0; j++) begin
            @(negedge sys_clk);
            if (j == 0)  tx_data  = 8'hE4;  // next byte, valid stays high
            if (j == 21) tx_valid = 1'b0;   // second accept was edge E+21
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got sym=%b rdy=%b busy=%b done=%b exp sym=%b rdy=%b busy=%b done=%b",
                         j, obs.sym, obs.ready, obs.busy, obs.done, e.sym, e.ready, e.busy, e.done);
            end
        end
    endtask

    task automatic test_min_period();
        obs_t e;
        sel_p1 = 1'b1;
        q.delete();
        push_frame(8'hFF, 1);
        push_idle(1'b1);
        push_frame(8'h4E, 1);
        push_idle(1'b1);
        push_idle(1'b0);
        @(negedge sys_clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(posedge sys_clk);
        for (int j = 0; q.size() > 0; j++) begin
            @(negedge sys_clk);
            if (j == 0) tx_valid = 1'b0;
            if (j == 5) begin               // earliest next accept at E+6
                tx_data  = 8'h4E;
                tx_valid = 1'b1;
            end
            if (j == 6) tx_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL min_period[%0d]: got sym=%b rdy=%b busy=%b done=%b exp sym=%b rdy=%b busy=%b done=%b",
                         j, obs.sym, obs.ready, obs.busy, obs.done, e.sym, e.ready, e.busy, e.done);
            end
        end
        sel_p1 = 1'b0;
    endtask

    task automatic test_mid_frame_reset();
        obs_t e;
        obs_t exp_o;
        sel_p1 = 1'b0;
        q.delete();
        push_frame(8'hA5, 4);
        @(negedge sys_clk);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge sys_clk);
        // Follow the frame up to the first cycle of dibit 2 (sample 12).
        for (int j = 0; j <= 12; j++) begin
            @(negedge sys_clk);
            if (j == 0) tx_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mid_reset_pre[%0d]: got %b exp %b", j, obs, e);
            end
        end
        q.delete();
        // Assert reset between clock edges; outputs must clear at once.
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        exp_o = '{sym: IDLE_SYM, ready: 1'b1, busy: 1'b0, done: 1'b0};
        checks++;
        if (obs !== exp_o) begin
            errors++;
            $display("FAIL mid_reset_async: got %b exp %b", obs, exp_o);
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        // Abandoned frame must never produce frame_done.
        for (int j = 0; j < 12; j++) push_idle(1'b0);
        for (int j = 0; q.size() > 0; j++) begin
            @(negedge sys_clk);
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mid_reset_idle[%0d]: got %b exp %b", j, obs, e);
            end
        end
        // A following byte goes out complete and correct.
        push_frame(8'h3C, 4);
        push_idle(1'b1);
        push_idle(1'b0);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(posedge sys_clk);
        for (int j = 0; q.size() > 0; j++) begin
            @(negedge sys_clk);
            if (j == 0) tx_valid = 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mid_reset_next[%0d]: got sym=%b rdy=%b busy=%b done=%b exp sym=%b rdy=%b busy=%b done=%b",
                         j, obs.sym, obs.ready, obs.busy, obs.done, e.sym, e.ready, e.busy, e.done);
            end
        end
    endtask

    task automatic test_data_stability();
        obs_t e;
        sel_p1 = 1'b0;
        q.delete();
        push_frame(8'h96, 4);
        push_idle(1'b1);
        push_idle(1'b0);
        @(negedge sys_clk);
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        @(posedge sys_clk);
        for (int j = 0; q.size() > 0; j++) begin
            @(negedge sys_clk);
            // Scramble inputs while the frame is in flight; valid is dropped
            // before the frame ends so no new accept can occur.
            tx_data  = 8'($urandom);
            tx_valid = (j < 19) ? 1'($urandom) : 1'b0;
            e = q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL data_stability[%0d]: got sym=%b rdy=%b busy=%b done=%b exp sym=%b rdy=%b busy=%b done=%b",
                         j, obs.sym, obs.ready, obs.busy, obs.done, e.sym, e.ready, e.busy, e.done);
            end
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        sel_p1    = 1'b0;
        sys_rst_n = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;

        test_reset();
        settle(2);
        test_single_frame();
        settle(25);
        test_back_to_back();
        settle(25);
        test_min_period();
        settle(25);
        test_mid_frame_reset();
        settle(25);
        test_data_stability();
        settle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dibit_tx.md
# dibit_tx

Byte-to-dibit line transmitter. Accepts one 8-bit byte per valid/ready handshake and drives it onto a 2-bit symbol bus as a preamble symbol followed by four data dibits, MSB first, each held for a programmable number of clocks. It is the transmitting end of the 2-bit symbol link. Its registered `out[1:0]` feeds the 2-bit input register stage of the receiving side directly, with no glue logic.

## Interface
- `SYM_PERIOD`, default 4: clocks per symbol. Legal range is ≥ 1.
- `IDLE_SYM`, default 2'b00: symbol driven between frames. Must not equal 2'b11.
- `sys_clk` input, 1 bit: clock, rising edge.
- `sys_rst_n` input, 1 bit: reset, asynchronous, active-low.
- `tx_data` input, 8 bits: byte to send. Sampled only on accept.
- `tx_valid` input, 1 bit: `tx_data` is valid.
- `tx_ready` output, 1 bit: block can accept a byte. Registered.
- `out` output, 2 bits: symbol bus. Registered.
- `busy` output, 1 bit: a frame is in progress. Registered.
- `frame_done` output, 1 bit: one-cycle pulse when a frame completes. Registered.

## Operation
- **States**
  - IDLE: `out`=IDLE_SYM, `tx_ready`=1, `busy`=0.
  - PRE: `out`=2'b11.
  - DATA: `out`=current dibit.
- **Accept:** occurs on a rising edge where `tx_valid`=1 and `tx_ready`=1 are both sampled.
  - `tx_data` is captured into an internal shift register.
  - State moves IDLE→PRE, the symbol counter is cleared, and the dibit index is cleared.
  - Later changes on `tx_data` or `tx_valid` do not affect the frame in flight.
- **Symbol counter:** counts 0..SYM_PERIOD-1.
  - On terminal count in PRE: go to DATA with index 0.
  - On terminal count in DATA with index < 3: increment the index.
  - On terminal count in DATA with index = 3: go to IDLE.
- **Data order:** dibit index 0..3 maps to `tx_data[7:6]`, `[5:4]`, `[3:2]`, `[1:0]`.
- **Ready rule:** `tx_ready` = (state == IDLE). No accept is possible while in PRE or DATA; `tx_valid` is ignored there.
- **Protocol expectation:** a producer holding `tx_valid` high keeps `tx_data` stable until the accept.
- **`frame_done`:** asserted for exactly the first cycle after returning to IDLE.
- **Reset values** (asynchronous, any state, including mid-frame):
  - `out`=IDLE_SYM, `tx_ready`=1, `busy`=0, `frame_done`=0.
  - State=IDLE; counter, index and shift register cleared.
  - A partially sent frame is abandoned. No `frame_done` is issued for it.
- **Counter width:** $clog2(SYM_PERIOD) bits, minimum 1. SYM_PERIOD=1 is legal: every symbol lasts one clock.

## Timing
- Let E be the accepting edge and P be SYM_PERIOD.
- **Edges E+1 .. E+P** (the P cycles after E): `out`=2'b11, `busy`=1, `tx_ready`=0.
- **Data symbol k (k=0..3):** `out` holds dibit k for the P cycles after edge E+(k+1)P.
- **Edge E+5P:** `out`=IDLE_SYM, `tx_ready`=1, `busy`=0, `frame_done`=1 for one cycle.
- **Next frame:** the earliest next accept is edge E+5P+1.
  - At least one IDLE_SYM cycle always separates frames.
  - Back-to-back throughput is one byte per 5P+1 clocks.
- **Latency:** first preamble symbol appears 1 clock after the accept; the last data symbol ends 5P clocks after the accept.
- **Held `tx_valid`:** if asserted during a frame, it is accepted at the first edge with `tx_ready`=1. No byte is dropped or duplicated.

## Test plan
- **Reset check** (P=4): hold `sys_rst_n`=0 → `out`=2'b00, `tx_ready`=1, `busy`=0, `frame_done`=0. Release reset with `tx_valid`=0 for 20 clocks → no change.
- **Single frame** (P=4, `tx_data`=8'hB4, one-cycle valid) → `out` sequence 11,10,11,01,00, each symbol exactly 4 clocks. `frame_done` pulses once at E+20. `tx_ready` is low for exactly 20 clocks.
- **Back-to-back** (P=4): bytes 8'h1B then 8'hE4, `tx_valid` held high → second accept at edge E+21. Dibits are 00,01,10,11 then 11,10,01,00, each preceded by 11. Exactly one IDLE_SYM clock between frames.
- **Minimum period** (P=1, `tx_data`=8'hFF) → `out`=11 for 5 consecutive clocks, then 00. `frame_done` at E+5. Next accept possible at E+6.
- **Mid-frame reset** (P=4): assert reset during dibit 2 of 8'hA5 → `out`=00 and `tx_ready`=1 immediately (asynchronously). No `frame_done`. A following byte 8'h3C transmits complete and correct.
- **Data stability:** change `tx_data` every clock after accepting 8'h96 → transmitted dibits are still 10,01,01,10.
